// File: rtl/pc_redirect.sv
// Fetch PC register and next-PC select: decode recovery > BTB target > PCF+4.
// Optional perf counters (PredCnt/MissCnt) when PC_REDIRECT_PERF_EN is defined.
module pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  PCControls,
  input  logic [31:0] PCCache,
  input  logic [31:0] PCD,
  input  logic [31:0] PCBranchD,
  input  logic [31:0] PCJumpD,
  input  logic        StallF,
  output logic [31:0] PCF,
  output logic        FlushD,
  output logic        Pending
`ifdef PC_REDIRECT_PERF_EN
  ,
  output logic [31:0] PredCnt,
  output logic [31:0] MissCnt
`endif
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pcf;
  logic [31:0] r_held;
  logic        r_pending;

  logic        w_rec_v;
  logic [31:0] w_rec_t;
  logic        w_hit;
  logic        w_flush;

  // Recovery decode: mispredicted-taken beats missed branch beats missed jump.
  function automatic logic [31:0] rec_target(input logic [3:0]  ctl,
                                             input logic [31:0] pcd,
                                             input logic [31:0] br_t,
                                             input logic [31:0] jp_t);
    logic [31:0] t;
    if (ctl[3]) begin
      t = pcd + 32'd4;
    end else if (ctl[2]) begin
      t = br_t;
    end else if (ctl[1]) begin
      t = jp_t;
    end else begin
      t = 32'h0000_0000;
    end
    return t;
  endfunction

  // Decode recovery request and the combinational IF/ID flush.
  always_comb begin
    w_rec_v = |PCControls[3:1];
    w_hit   = PCControls[0];
    w_rec_t = rec_target(PCControls, PCD, PCBranchD, PCJumpD);
    w_flush = 1'b0;
    if (reset || StallF) begin
      w_flush = 1'b0;
    end else begin
      case (r_state)
        ST_RUN:  w_flush = w_rec_v;
        ST_HOLD: w_flush = 1'b1;
        default: w_flush = 1'b0;
      endcase
    end
  end

  // PC register and RUN/HOLD state; a recovery seen under stall is parked until the stall drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_RUN;
      r_pcf     <= RESET_PC;
      r_held    <= 32'h0000_0000;
      r_pending <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!StallF) begin
            if (w_rec_v) begin
              r_pcf <= w_rec_t;
            end else if (w_hit) begin
              r_pcf <= PCCache;
            end else begin
              r_pcf <= r_pcf + 32'd4;
            end
          end else if (w_rec_v) begin
            r_held    <= w_rec_t;
            r_pending <= 1'b1;
            r_state   <= ST_HOLD;
          end else begin
            r_pcf <= r_pcf;
          end
        end
        ST_HOLD: begin
          // Controls are ignored here: the first parked target wins.
          if (!StallF) begin
            r_pcf     <= r_held;
            r_pending <= 1'b0;
            r_state   <= ST_RUN;
          end else begin
            r_pcf <= r_pcf;
          end
        end
        default: begin
          r_state   <= ST_RUN;
          r_pending <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] r_pred_cnt;
  logic [31:0] r_miss_cnt;

  // Prediction-hit and applied-recovery counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pred_cnt <= 32'h0000_0000;
      r_miss_cnt <= 32'h0000_0000;
    end else begin
      if ((r_state == ST_RUN) && !StallF && w_hit) begin
        r_pred_cnt <= r_pred_cnt + 32'd1;
      end
      if (w_flush) begin
        r_miss_cnt <= r_miss_cnt + 32'd1;
      end
    end
  end

  assign PredCnt = r_pred_cnt;
  assign MissCnt = r_miss_cnt;
`endif

  assign PCF     = r_pcf;
  assign FlushD  = w_flush;
  assign Pending = r_pending;

endmodule

// File: tb/tb_pc_redirect.sv
// Directed self-checking bench for pc_redirect (also checks perf counters when
// PC_REDIRECT_PERF_EN is defined).
module tb_pc_redirect;

  logic        clk;
  logic        reset;
  logic [3:0]  PCControls;
  logic [31:0] PCCache;
  logic [31:0] PCD;
  logic [31:0] PCBranchD;
  logic [31:0] PCJumpD;
  logic        StallF;
  logic [31:0] PCF;
  logic        FlushD;
  logic        Pending;
`ifdef PC_REDIRECT_PERF_EN
  logic [31:0] PredCnt;
  logic [31:0] MissCnt;
`endif

  int total_cnt;
  int bad_cnt;

  pc_redirect #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .PCControls (PCControls),
    .PCCache    (PCCache),
    .PCD        (PCD),
    .PCBranchD  (PCBranchD),
    .PCJumpD    (PCJumpD),
    .StallF     (StallF),
    .PCF        (PCF),
    .FlushD     (FlushD),
    .Pending    (Pending)
`ifdef PC_REDIRECT_PERF_EN
    ,
    .PredCnt    (PredCnt),
    .MissCnt    (MissCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total_cnt  = 0;
    bad_cnt    = 0;
    reset      = 1'b1;
    PCControls = 4'b0000;
    PCCache    = 32'h0;
    PCD        = 32'h0;
    PCBranchD  = 32'h0;
    PCJumpD    = 32'h0;
    StallF     = 1'b0;
    tick();
    tick();
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_pend", {31'd0, Pending}, 32'd0);
    chk("rst_flush", {31'd0, FlushD}, 32'd0);

    // 1: sequential fetch
    reset = 1'b0;
    #1;
    chk("seq0", PCF, 32'h0);
    tick();
    chk("seq4", PCF, 32'h4);
    tick();
    chk("seq8", PCF, 32'h8);
    chk("seq_flush", {31'd0, FlushD}, 32'd0);
    tick();
    chk("seqC", PCF, 32'hC);

    // 2: BTB hit to 0x40 then 0x100
    PCControls = 4'b0001;
    PCCache    = 32'h40;
    tick();
    chk("hit40", PCF, 32'h40);
    PCCache = 32'h100;
    #1;
    chk("hit_flush", {31'd0, FlushD}, 32'd0);
    tick();
    chk("hit100", PCF, 32'h100);

    // 3: branch recovery beats HitF
    PCControls = 4'b0101;
    PCBranchD  = 32'h200;
    PCCache    = 32'h300;
    #1;
    chk("br_flush", {31'd0, FlushD}, 32'd1);
    tick();
    chk("br_pcf", PCF, 32'h200);

    // 4: mispredicted-taken -> PCD+4, priority and wrap
    PCControls = 4'b1000;
    PCD        = 32'h80;
    #1;
    chk("nt_flush", {31'd0, FlushD}, 32'd1);
    tick();
    chk("nt_pcf", PCF, 32'h84);
    PCControls = 4'b1110;
    PCD        = 32'h90;
    PCJumpD    = 32'h700;
    tick();
    chk("prio_pcf", PCF, 32'h94);
    PCControls = 4'b1000;
    PCD        = 32'hFFFF_FFFC;
    tick();
    chk("wrap_pcf", PCF, 32'h0);
    PCControls = 4'b0000;
    #1;
    chk("idle_flush", {31'd0, FlushD}, 32'd0);
    tick();
    chk("idle_pcf", PCF, 32'h4);

    // 5: recovery under stall is held; first target wins
    StallF     = 1'b1;
    PCControls = 4'b0010;
    PCJumpD    = 32'h500;
    #1;
    chk("stall_flush", {31'd0, FlushD}, 32'd0);
    tick();
    chk("stall_pcf1", PCF, 32'h4);
    chk("stall_pend1", {31'd0, Pending}, 32'd1);
    PCControls = 4'b0101;
    PCBranchD  = 32'h600;
    tick();
    chk("stall_pcf2", PCF, 32'h4);
    chk("hold_flush", {31'd0, FlushD}, 32'd0);
    tick();
    chk("stall_pend3", {31'd0, Pending}, 32'd1);
    StallF     = 1'b0;
    PCControls = 4'b0000;
    #1;
    chk("rel_flush", {31'd0, FlushD}, 32'd1);
    tick();
    chk("rel_pcf", PCF, 32'h500);
    chk("rel_pend", {31'd0, Pending}, 32'd0);
    chk("post_flush", {31'd0, FlushD}, 32'd0);
    tick();
    chk("post_pcf", PCF, 32'h504);
`ifdef PC_REDIRECT_PERF_EN
    chk("pred_cnt", PredCnt, 32'd3);
    chk("miss_cnt", MissCnt, 32'd5);
`endif

    // 6: reset during HOLD drops the parked target
    StallF     = 1'b1;
    PCControls = 4'b0010;
    PCJumpD    = 32'h500;
    tick();
    chk("h6_pend", {31'd0, Pending}, 32'd1);
    reset      = 1'b1;
    StallF     = 1'b0;
    PCControls = 4'b0000;
    #1;
    chk("h6_rst_flush", {31'd0, FlushD}, 32'd0);
    tick();
    chk("h6_pcf", PCF, 32'h0);
    chk("h6_pend0", {31'd0, Pending}, 32'd0);
`ifdef PC_REDIRECT_PERF_EN
    chk("h6_pred0", PredCnt, 32'd0);
    chk("h6_miss0", MissCnt, 32'd0);
`endif
    reset = 1'b0;
    #1;
    chk("h6_flush", {31'd0, FlushD}, 32'd0);
    tick();
    chk("h6_pcf4", PCF, 32'h4);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
